// File: rtl/noc_mem_arbiter.sv
// N-channel round-robin request arbiter in front of a single memory interface.
// Buffers per-channel requests, tags granted requests with the channel id and routes read responses back.
module noc_mem_arbiter #(
  parameter int N_CH            = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 128,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int ID_W           = $clog2(N_CH)
) (
  input  logic                     fclk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req_valid,
  output logic [N_CH-1:0]          req_ready,
  input  logic [N_CH-1:0]          req_we,
  input  logic [N_CH*ADDR_W-1:0]   req_addr,
  input  logic [N_CH*DATA_W-1:0]   req_data,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [DATA_W-1:0]        mem_req_data,
  output logic [ID_W-1:0]          mem_req_id,
  input  logic                     mem_rsp_valid,
  input  logic [ID_W-1:0]          mem_rsp_id,
  input  logic [DATA_W-1:0]        mem_rsp_data,
  output logic [N_CH-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     err,
  output logic                     arb_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = 4;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
  state_t state;

  logic              fifo_we   [N_CH][FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [N_CH][FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [N_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr    [N_CH];
  logic [PTR_W-1:0]  rd_ptr    [N_CH];
  logic [PTR_W:0]    fill      [N_CH];
  logic [CNT_W-1:0]  out_cnt   [N_CH];

  logic [N_CH-1:0] push, pop, elig, head_we, rd_inc, rsp_hit;
  logic [ID_W-1:0] rr_ptr, grant, cand, nxt_ptr;
  logic            grant_valid, free_slot, rsp_ok;

  assign arb_state = state;

  // Handshakes: a transfer happens at a rising fclk edge where valid and ready are both 1;
  // ready never depends on valid, and a valid request holds its payload stable until accepted.
  always_comb begin
    req_ready = '0;
    push      = '0;
    head_we   = '0;
    elig      = '0;
    rsp_hit   = '0;
    for (int i = 0; i < N_CH; i++) begin
      req_ready[i] = rst && (fill[i] != FULL_CNT);
      push[i]      = req_valid[i] && req_ready[i];
      head_we[i]   = fifo_we[i][rd_ptr[i]];
      elig[i]      = (fill[i] != '0) &&
                     (head_we[i] || (out_cnt[i] < CNT_W'(MAX_OUTSTANDING)));
      rsp_hit[i]   = mem_rsp_valid && (mem_rsp_id == ID_W'(i)) && (out_cnt[i] != '0);
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    cand        = '0;
    for (int off = 0; off < N_CH; off++) begin
      cand = ((int'(rr_ptr) + off) >= N_CH) ? ID_W'(int'(rr_ptr) + off - N_CH)
                                            : ID_W'(int'(rr_ptr) + off);
      if (!grant_valid && elig[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
  end

  assign free_slot = !mem_req_valid || mem_req_ready;
  assign nxt_ptr   = (int'(grant) == N_CH - 1) ? '0 : grant + ID_W'(1);
  assign rsp_ok    = |rsp_hit;

  always_comb begin
    pop    = '0;
    rd_inc = '0;
    for (int i = 0; i < N_CH; i++) begin
      pop[i]    = free_slot && grant_valid && (grant == ID_W'(i));
      rd_inc[i] = pop[i] && !head_we[i];
    end
  end

  // Storage has no reset; emptiness is tracked solely by the pointers and fill counts.
  always_ff @(posedge fclk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (push[i]) begin
        fifo_we[i][wr_ptr[i]]   <= req_we[i];
        fifo_addr[i][wr_ptr[i]] <= req_addr[i*ADDR_W +: ADDR_W];
        fifo_data[i][wr_ptr[i]] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr[i]  <= '0;
        rd_ptr[i]  <= '0;
        fill[i]    <= '0;
        out_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push[i] && !pop[i])      fill[i] <= fill[i] + (PTR_W+1)'(1);
        else if (!push[i] && pop[i]) fill[i] <= fill[i] - (PTR_W+1)'(1);
        if (rd_inc[i] && !rsp_hit[i])      out_cnt[i] <= out_cnt[i] + CNT_W'(1);
        else if (!rd_inc[i] && rsp_hit[i]) out_cnt[i] <= out_cnt[i] - CNT_W'(1);
      end
    end
  end

  // A new grant may load in the same cycle the held request is accepted.
  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_req_id    <= '0;
    end else if (free_slot) begin
      if (grant_valid) begin
        state         <= HOLD;
        rr_ptr        <= nxt_ptr;
        mem_req_valid <= 1'b1;
        mem_req_we    <= head_we[grant];
        mem_req_addr  <= fifo_addr[grant][rd_ptr[grant]];
        mem_req_data  <= fifo_data[grant][rd_ptr[grant]];
        mem_req_id    <= grant;
      end else begin
        state         <= IDLE;
        mem_req_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= rsp_hit;
      if (rsp_ok) rsp_data <= mem_rsp_data;
      else if (mem_rsp_valid) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_mem_arbiter.sv
// Directed bench for noc_mem_arbiter: write path, round-robin interleave, stall/backpressure,
// outstanding limit, response routing and reset recovery.
module tb_noc_mem_arbiter;

  localparam int N_CH   = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int ID_W   = 1;

  logic                   fclk;
  logic                   rst;
  logic [N_CH-1:0]        req_valid;
  logic [N_CH-1:0]        req_ready;
  logic [N_CH-1:0]        req_we;
  logic [N_CH*ADDR_W-1:0] req_addr;
  logic [N_CH*DATA_W-1:0] req_data;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic                   mem_req_we;
  logic [ADDR_W-1:0]      mem_req_addr;
  logic [DATA_W-1:0]      mem_req_data;
  logic [ID_W-1:0]        mem_req_id;
  logic                   mem_rsp_valid;
  logic [ID_W-1:0]        mem_rsp_id;
  logic [DATA_W-1:0]      mem_rsp_data;
  logic [N_CH-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic                   err;
  logic                   arb_state;

  int vectors;
  int miscompares;
  logic [ID_W+ADDR_W-1:0] exp_q[$];
  logic [ID_W+ADDR_W-1:0] exp_e;
  logic [DATA_W-1:0]      pat_a5;

  noc_mem_arbiter #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .MAX_OUTSTANDING(4)
  ) dut (
    .fclk(fclk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_id(mem_req_id),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_id(mem_rsp_id), .mem_rsp_data(mem_rsp_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err), .arb_state(arb_state)
  );

  // clock
  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid     = '0;
    req_we        = '0;
    req_addr      = '0;
    req_data      = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_id    = '0;
    mem_rsp_data  = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pat_a5      = {16{8'hA5}};

    // reset state
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_mem_addr", mem_req_addr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_err", err, 0);
    check("rst_state", arb_state, 0);
    rst = 1'b1;
    tick();
    check("idle_req_ready", req_ready, 2'b11);

    // 1: single write from ch0
    mem_req_ready = 1'b1;
    req_valid     = 2'b01;
    req_we        = 2'b01;
    req_addr      = {32'h0, 32'h100};
    req_data      = {128'h0, pat_a5};
    tick();
    req_valid = '0;
    check("t1_no_early_valid", mem_req_valid, 0);
    tick();
    check("t1_valid", mem_req_valid, 1);
    check("t1_we", mem_req_we, 1);
    check("t1_id", mem_req_id, 0);
    check("t1_addr", mem_req_addr, 32'h100);
    check("t1_data", mem_req_data, pat_a5);
    tick();
    check("t1_drain", mem_req_valid, 0);
    check("t1_no_rsp", rsp_valid, 0);

    // 2: round-robin interleave of 3 reads per channel
    reset_dut();
    mem_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({1'b0, 32'(32'h200 + k)});
      exp_q.push_back({1'b1, 32'(32'h300 + k)});
    end
    for (int cyc = 0; cyc < 7; cyc++) begin
      if (cyc < 3) begin
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {32'(32'h300 + cyc), 32'(32'h200 + cyc)};
      end else begin
        req_valid = '0;
      end
      tick();
      if (cyc == 0) begin
        check("t2_first_latency", mem_req_valid, 0);
      end else begin
        exp_e = exp_q.pop_front();
        check("t2_valid", mem_req_valid, 1);
        check("t2_id", mem_req_id, exp_e[ADDR_W]);
        check("t2_addr", mem_req_addr, exp_e[ADDR_W-1:0]);
      end
    end
    tick();
    check("t2_drain", mem_req_valid, 0);
    check("t2_cnt0", dut.out_cnt[0], 3);
    check("t2_cnt1", dut.out_cnt[1], 3);
    mem_rsp_valid = 1'b1;
    mem_rsp_id    = 1'b0;
    mem_rsp_data  = 128'h1111;
    tick();
    check("t2_rsp0_valid", rsp_valid, 2'b01);
    check("t2_rsp0_data", rsp_data, 128'h1111);
    mem_rsp_id   = 1'b1;
    mem_rsp_data = 128'h2222;
    tick();
    mem_rsp_valid = 1'b0;
    check("t2_rsp1_valid", rsp_valid, 2'b10);
    check("t2_rsp1_data", rsp_data, 128'h2222);
    tick();
    check("t2_rsp_pulse", rsp_valid, 2'b00);
    check("t2_rsp_hold", rsp_data, 128'h2222);
    check("t2_cnt0_after", dut.out_cnt[0], 2);
    check("t2_err", err, 0);

    // 3: memory stall, stable payload, FIFO fill and backpressure
    reset_dut();
    mem_req_ready = 1'b0;
    req_valid     = 2'b01;
    req_we        = 2'b00;
    req_addr      = {32'h0, 32'h400};
    req_data      = {128'h0, 128'h400};
    tick();
    check("t3_no_early_valid", mem_req_valid, 0);
    for (int k = 1; k <= 4; k++) begin
      req_addr = {32'h0, 32'(32'h400 + k)};
      req_data = {128'h0, 128'(32'h400 + k)};
      tick();
      check("t3_addr_stable", mem_req_addr, 32'h400);
      check("t3_id_stable", mem_req_id, 0);
    end
    check("t3_backpressure", req_ready, 2'b10);
    req_valid = '0;
    tick();
    check("t3_hold_valid", mem_req_valid, 1);
    check("t3_hold_addr", mem_req_addr, 32'h400);
    check("t3_hold_data", mem_req_data, 128'h400);
    check("t3_hold_state", arb_state, 1);
    mem_req_ready = 1'b1;
    tick();
    check("t3_next_addr", mem_req_addr, 32'h401);
    check("t3_ready_back", req_ready, 2'b11);

    // 4: outstanding limit on ch1, write queued behind blocked read, ch0 still served
    reset_dut();
    mem_req_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req_valid = 2'b10;
      req_we    = 2'b00;
      req_addr  = {32'(32'h500 + k), 32'h0};
      tick();
      if (k == 0) begin
        check("t4_first_latency", mem_req_valid, 0);
      end else begin
        check("t4_id", mem_req_id, 1);
        check("t4_addr", mem_req_addr, 32'(32'h500 + k - 1));
      end
    end
    req_we   = 2'b10;
    req_addr = {32'h5FF, 32'h0};
    tick();
    check("t4_limit_blocks", mem_req_valid, 0);
    req_valid = 2'b01;
    req_we    = 2'b01;
    req_addr  = {32'h0, 32'h600};
    tick();
    req_valid = '0;
    check("t4_still_blocked", mem_req_valid, 0);
    tick();
    check("t4_ch0_valid", mem_req_valid, 1);
    check("t4_ch0_id", mem_req_id, 0);
    check("t4_ch0_addr", mem_req_addr, 32'h600);
    tick();
    check("t4_ch1_waits", mem_req_valid, 0);
    mem_rsp_valid = 1'b1;
    mem_rsp_id    = 1'b1;
    mem_rsp_data  = 128'h5A5A;
    tick();
    mem_rsp_valid = 1'b0;
    check("t4_rsp_valid", rsp_valid, 2'b10);
    check("t4_rsp_data", rsp_data, 128'h5A5A);
    check("t4_not_yet", mem_req_valid, 0);
    tick();
    check("t4_read5_addr", mem_req_addr, 32'h504);
    check("t4_read5_we", mem_req_we, 0);
    tick();
    check("t4_write_addr", mem_req_addr, 32'h5FF);
    check("t4_write_we", mem_req_we, 1);
    tick();
    check("t4_drain", mem_req_valid, 0);

    // 5: response in the same cycle as a ch1 read issue, then an unexpected response
    reset_dut();
    mem_req_ready = 1'b1;
    req_valid     = 2'b10;
    req_we        = 2'b00;
    req_addr      = {32'h700, 32'h0};
    tick();
    req_addr = {32'h701, 32'h0};
    tick();
    req_valid     = '0;
    mem_rsp_valid = 1'b1;
    mem_rsp_id    = 1'b1;
    mem_rsp_data  = 128'hDEAD;
    tick();
    check("t5_rsp_valid", rsp_valid, 2'b10);
    check("t5_rsp_data", rsp_data, 128'hDEAD);
    check("t5_issue_addr", mem_req_addr, 32'h701);
    check("t5_cnt_same", dut.out_cnt[1], 1);
    mem_rsp_data = 128'hBEEF;
    tick();
    check("t5_rsp2_data", rsp_data, 128'hBEEF);
    check("t5_cnt_zero", dut.out_cnt[1], 0);
    check("t5_no_err", err, 0);
    mem_rsp_data = 128'hCAFE;
    tick();
    mem_rsp_valid = 1'b0;
    check("t5_drop_valid", rsp_valid, 2'b00);
    check("t5_drop_data", rsp_data, 128'hBEEF);
    check("t5_err", err, 1);
    tick();
    check("t5_err_sticky", err, 1);

    // 6: reset mid-burst, then a stale response
    reset_dut();
    mem_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid = 2'b11;
      req_we    = 2'b00;
      req_addr  = {32'(32'h900 + k), 32'(32'h800 + k)};
      req_data  = {128'(32'h900 + k), 128'(32'h800 + k)};
      tick();
    end
    check("t6_busy", mem_req_valid, 1);
    rst       = 1'b0;
    req_valid = '0;
    #1;
    check("t6_rst_valid", mem_req_valid, 0);
    check("t6_rst_addr", mem_req_addr, 0);
    check("t6_rst_data", mem_req_data, 0);
    check("t6_rst_id", mem_req_id, 0);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_rsp", rsp_valid, 0);
    check("t6_rst_state", arb_state, 0);
    tick();
    rst = 1'b1;
    tick();
    check("t6_discarded", mem_req_valid, 0);
    check("t6_ready", req_ready, 2'b11);
    mem_rsp_valid = 1'b1;
    mem_rsp_id    = 1'b0;
    mem_rsp_data  = 128'h77;
    tick();
    mem_rsp_valid = 1'b0;
    check("t6_stale_err", err, 1);
    check("t6_stale_rsp", rsp_valid, 0);
    check("t6_stale_data", rsp_data, 0);
    tick();
    check("t6_quiet", mem_req_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
